// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer:
// opcode/func encodings, FSM state type, decoded class and control bundle.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Exactly one flag is set for any instruction word.
    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic load;
        logic store;
        logic jr;
        logic illegal;
    } instr_class_t;

    typedef struct packed {
        logic instr_read;
        logic data_read;
        logic data_write;
        logic reg_dst;
        logic mem_to_reg;
        logic alu_src;
        logic reg_write;
        logic active;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction-port, data-port and datapath-control bundle of the sequencer.
// master = the control sequencer, slave = memories plus register/ALU datapath.
interface mips_multicycle_ctrl_if;

    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_readdata;
    logic        instr_waitrequest;

    logic        data_read;
    logic        data_write;
    logic        data_waitrequest;

    logic [31:0] reg_read_data_0;

    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrc;
    logic        RegWrite;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  ALUOp;
    logic [5:0]  func_code;
    logic [15:0] alu_immediate;

    logic        active;
    logic        fault;

    modport master (
        output instr_address, instr_read,
        input  instr_readdata, instr_waitrequest,
        output data_read, data_write,
        input  data_waitrequest,
        input  reg_read_data_0,
        output RegDst, MemtoReg, ALUSrc, RegWrite,
        output rs, rt, rd, ALUOp, func_code, alu_immediate,
        output active, fault
    );

    modport slave (
        input  instr_address, instr_read,
        output instr_readdata, instr_waitrequest,
        input  data_read, data_write,
        output data_waitrequest,
        output reg_read_data_0,
        input  RegDst, MemtoReg, ALUSrc, RegWrite,
        input  rs, rt, rd, ALUOp, func_code, alu_immediate,
        input  active, fault
    );

endinterface

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/func fields in, one-hot class out.
module mips_decode
    import mips_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t cls
);

    always_comb begin
        cls = '{default: 1'b0};
        unique case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    cls.alu_r = 1'b1;
                end else if (funct == FN_JR) begin
                    cls.jr = 1'b1;
                end else begin
                    cls.illegal = 1'b1;
                end
            end
            OP_ADDIU: cls.alu_i   = 1'b1;
            OP_LW:    cls.load    = 1'b1;
            OP_SW:    cls.store   = 1'b1;
            default:  cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/EXEC/MEM/HALT sequencer for the 5-instruction MIPS core.
// Owns PC and IR; all strobes/controls are registered for the state being entered.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    mips_multicycle_ctrl_if.master        bus
);

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         fault_q, fault_d;
    ctrl_t        ctrl_q, ctrl_d;

    instr_class_t cls;
    logic         fetch_accept;
    logic         mem_done;
    logic         load_commit;
    logic         unused_ir_bits;

    assign fetch_accept = (state_q == ST_FETCH) && ctrl_q.instr_read && !bus.instr_waitrequest;
    assign mem_done     = (state_q == ST_MEM) && !bus.data_waitrequest;

    // The IR being worked on in the next state; equals ir_q except on the accepting fetch.
    always_comb begin
        ir_d = ir_q;
        if (fetch_accept) begin
            ir_d = bus.instr_readdata;
        end
    end

    mips_decode u_decode (
        .op    (ir_d[31:26]),
        .funct (ir_d[5:0]),
        .cls   (cls)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            ST_FETCH: begin
                if (fetch_accept) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.illegal) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else if (cls.load || cls.store) begin
                    state_d = ST_MEM;
                end else if (cls.jr) begin
                    pc_d    = bus.reg_read_data_0;
                    state_d = (bus.reg_read_data_0 == 32'd0) ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (mem_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Controls for the state being entered, so they are valid from its first cycle.
    always_comb begin
        ctrl_d        = CTRL_IDLE;
        ctrl_d.active = (state_d != ST_HALT);
        unique case (state_d)
            ST_FETCH: begin
                ctrl_d.instr_read = 1'b1;
            end
            ST_EXEC: begin
                if (cls.alu_r) begin
                    ctrl_d.reg_write = (ir_d[15:11] != 5'd0);
                end else if (cls.alu_i) begin
                    ctrl_d.reg_dst   = 1'b1;
                    ctrl_d.alu_src   = 1'b1;
                    ctrl_d.reg_write = (ir_d[20:16] != 5'd0);
                end else if (cls.load || cls.store) begin
                    ctrl_d.alu_src = 1'b1;
                end
            end
            ST_MEM: begin
                ctrl_d.alu_src = 1'b1;
                if (cls.load) begin
                    ctrl_d.data_read  = 1'b1;
                    ctrl_d.reg_dst    = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end else if (cls.store) begin
                    ctrl_d.data_write = 1'b1;
                end
            end
            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_VECTOR;
            ir_q          <= 32'd0;
            fault_q       <= 1'b0;
            ctrl_q        <= CTRL_IDLE;
            ctrl_q.active <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // The load writes back only in the cycle its data is returned; a reset aborts it.
    assign load_commit = (state_q == ST_MEM) && ctrl_q.data_read && !bus.data_waitrequest
                         && !reset && (ir_q[20:16] != 5'd0);

    assign bus.instr_address = pc_q;
    assign bus.instr_read    = ctrl_q.instr_read;
    assign bus.data_read     = ctrl_q.data_read;
    assign bus.data_write    = ctrl_q.data_write;
    assign bus.RegDst        = ctrl_q.reg_dst;
    assign bus.MemtoReg      = ctrl_q.mem_to_reg;
    assign bus.ALUSrc        = ctrl_q.alu_src;
    assign bus.RegWrite      = ctrl_q.reg_write | load_commit;
    assign bus.active        = ctrl_q.active;
    assign bus.fault         = fault_q;

    assign bus.rs            = ir_q[25:21];
    assign bus.rt            = ir_q[20:16];
    assign bus.rd            = ir_q[15:11];
    assign bus.ALUOp         = ir_q[31:26];
    assign bus.func_code     = ir_q[5:0];
    assign bus.alu_immediate = ir_q[15:0];

    assign unused_ir_bits = ^{ir_d[25:21], ir_d[10:6]};

endmodule
